// File: rtl/reaction_referee.sv
// reaction_referee: two-player reaction game controller with random countdown, first-flip arbitration and scoring.
module reaction_referee #(
  parameter int          WIN_SCORE    = 5,
  parameter int          MIN_DELAY_MS = 1000,
  parameter int          RAND_BITS    = 10,
  parameter int          TIMEOUT_MS   = 3000,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        start,
  input  logic        sw_p1,
  input  logic        sw_p2,
  output logic        armed,
  output logic [2:0]  p1_score,
  output logic [2:0]  p2_score,
  output logic [1:0]  winner,
  output logic        round_pulse,
  output logic [15:0] reaction_ms
);
  typedef enum logic [2:0] {IDLE, WAIT_REL, COUNTDOWN, ARMED, CHECK, GAMEOVER} state_t;
  state_t state, next;
  logic [2:0] st_s, p1_s, p2_s;
  logic [15:0] lfsr, cnt, rt;
  logic st_e, e1, e2, pulse, win1, win2, pun1, pun2, load, clr;
  localparam logic [2:0] WIN = 3'(WIN_SCORE);
  // two synchronizer stages plus one history stage for edge detection
  assign st_e = st_s[1] & ~st_s[2];
  assign e1   = p1_s[1] & ~p1_s[2];
  assign e2   = p2_s[1] & ~p2_s[2];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      st_s  <= '0;
      p1_s  <= '0;
      p2_s  <= '0;
      lfsr  <= LFSR_SEED;
      state <= IDLE;
    end else begin
      st_s  <= {st_s[1:0], start};
      p1_s  <= {p1_s[1:0], sw_p1};
      p2_s  <= {p2_s[1:0], sw_p2};
      lfsr  <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      state <= next;
    end
  always_comb begin
    next  = state;
    pulse = 1'b0;
    win1  = 1'b0;
    win2  = 1'b0;
    pun1  = 1'b0;
    pun2  = 1'b0;
    load  = 1'b0;
    clr   = 1'b0;
    case (state)
      IDLE:      next = st_e ? WAIT_REL : IDLE;
      WAIT_REL: begin
        load = !p1_s[1] && !p2_s[1];
        next = load ? COUNTDOWN : WAIT_REL;
      end
      COUNTDOWN: begin
        pun1  = e1;
        pun2  = e2;
        pulse = e1 | e2;
        next  = pulse ? WAIT_REL : (cnt == '0) ? ARMED : COUNTDOWN;
      end
      ARMED: begin
        win1  = e1 & ~e2;
        win2  = e2 & ~e1;
        pulse = e1 | e2 | (rt == 16'(TIMEOUT_MS));
        next  = (win1 | win2) ? CHECK : pulse ? WAIT_REL : ARMED;
      end
      CHECK:     next = (p1_score == WIN || p2_score == WIN) ? GAMEOVER : WAIT_REL;
      GAMEOVER: begin
        clr  = st_e;
        next = st_e ? WAIT_REL : GAMEOVER;
      end
      default:   next = IDLE;
    endcase
  end
  // edges win over a coincident tick because counting requires staying in the state
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt         <= '0;
      rt          <= '0;
      p1_score    <= '0;
      p2_score    <= '0;
      winner      <= '0;
      armed       <= 1'b0;
      round_pulse <= 1'b0;
      reaction_ms <= '0;
    end else begin
      cnt         <= load ? 16'(MIN_DELAY_MS) + 16'(lfsr[RAND_BITS-1:0]) :
                     (state == COUNTDOWN && next == COUNTDOWN && tick) ? cnt - 16'd1 : cnt;
      rt          <= (state == COUNTDOWN) ? '0 :
                     (state == ARMED && next == ARMED && tick && rt != 16'hFFFF) ? rt + 16'd1 : rt;
      p1_score    <= clr ? '0 : (win1 && p1_score != WIN) ? p1_score + 3'd1 :
                     (pun1 && p1_score != '0) ? p1_score - 3'd1 : p1_score;
      p2_score    <= clr ? '0 : (win2 && p2_score != WIN) ? p2_score + 3'd1 :
                     (pun2 && p2_score != '0) ? p2_score - 3'd1 : p2_score;
      winner      <= clr ? '0 : (state != CHECK) ? winner :
                     (p1_score == WIN) ? 2'b01 : (p2_score == WIN) ? 2'b10 : 2'b00;
      reaction_ms <= clr ? '0 : (win1 | win2) ? rt : reaction_ms;
      armed       <= next == ARMED;
      round_pulse <= pulse;
    end
endmodule

// File: tb/tb_reaction_referee.sv
// tb_reaction_referee: directed checks of countdown, scoring, punishment, tie, timeout, win and reset.
module tb_reaction_referee;
  logic clk, reset, tick, start, sw_p1, sw_p2;
  logic armed, round_pulse;
  logic [2:0] p1_score, p2_score;
  logic [1:0] winner;
  logic [15:0] reaction_ms;
  int total = 0, bad = 0, n;

  reaction_referee dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start), .sw_p1(sw_p1), .sw_p2(sw_p2),
    .armed(armed), .p1_score(p1_score), .p2_score(p2_score), .winner(winner),
    .round_pulse(round_pulse), .reaction_ms(reaction_ms)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // releases switches and ticks every cycle until the go LED lights, bounded
  task automatic go_armed(output int cycles);
    sw_p1 = 1'b0;
    sw_p2 = 1'b0;
    tick = 1'b1;
    cycles = 0;
    while (!armed && cycles < 2100) begin
      step(1);
      cycles++;
    end
    tick = 1'b0;
    chk("arm_reached", armed, 1);
  endtask

  // t ticks of reaction time, then flip; returns on the cycle the result is visible
  task automatic do_flip(input logic a, input logic b, input int t);
    tick = 1'b1;
    step(t);
    tick = 1'b0;
    sw_p1 = a;
    sw_p2 = b;
    step(3);
  endtask

  initial begin
    reset = 1'b0; tick = 1'b0; start = 1'b0; sw_p1 = 1'b0; sw_p2 = 1'b0;
    step(3);
    chk("rst_armed", armed, 0);
    chk("rst_p1", p1_score, 0);
    chk("rst_p2", p2_score, 0);
    chk("rst_winner", winner, 0);
    chk("rst_pulse", round_pulse, 0);
    chk("rst_react", reaction_ms, 0);
    reset = 1'b1;
    step(2);
    start = 1'b1;
    go_armed(n);
    start = 1'b0;
    chk("arm_delay_range", (n - 5 >= 1000 && n - 5 <= 2023), 1);
    do_flip(1, 0, 37);
    chk("r1_p1", p1_score, 1);
    chk("r1_p2", p2_score, 0);
    chk("r1_react", reaction_ms, 37);
    chk("r1_pulse", round_pulse, 1);
    chk("r1_armed", armed, 0);
    step(1);
    chk("r1_pulse_end", round_pulse, 0);
    chk("r1_winner", winner, 0);
    go_armed(n);
    do_flip(0, 1, 5);
    chk("r2_p2", p2_score, 1);
    chk("r2_react", reaction_ms, 5);
    go_armed(n);
    do_flip(0, 1, 9);
    chk("r3_p2", p2_score, 2);
    chk("r3_react", reaction_ms, 9);
    sw_p2 = 1'b0;
    step(6);
    chk("early1_pre_armed", armed, 0);
    sw_p2 = 1'b1;
    step(3);
    chk("early1_p2", p2_score, 1);
    chk("early1_pulse", round_pulse, 1);
    sw_p2 = 1'b0;
    step(6);
    sw_p2 = 1'b1;
    step(3);
    chk("early2_p2", p2_score, 0);
    sw_p2 = 1'b0;
    step(6);
    sw_p2 = 1'b1;
    step(3);
    chk("early3_p2_sat", p2_score, 0);
    chk("early3_pulse", round_pulse, 1);
    chk("early3_p1", p1_score, 1);
    go_armed(n);
    do_flip(1, 1, 4);
    chk("tie_p1", p1_score, 1);
    chk("tie_p2", p2_score, 0);
    chk("tie_react", reaction_ms, 9);
    chk("tie_pulse", round_pulse, 1);
    chk("tie_armed", armed, 0);
    step(1);
    chk("tie_pulse_end", round_pulse, 0);
    go_armed(n);
    tick = 1'b1;
    step(3000);
    chk("to_still_armed", armed, 1);
    chk("to_no_pulse", round_pulse, 0);
    step(1);
    tick = 1'b0;
    chk("to_armed", armed, 0);
    chk("to_pulse", round_pulse, 1);
    chk("to_p1", p1_score, 1);
    chk("to_p2", p2_score, 0);
    for (int i = 2; i <= 5; i++) begin
      go_armed(n);
      do_flip(1, 0, 10 + i);
      chk("win_p1", p1_score, 16'(i));
    end
    chk("win_react", reaction_ms, 15);
    chk("win_winner_early", winner, 0);
    step(1);
    chk("win_winner", winner, 1);
    step(20);
    chk("go_hold_winner", winner, 1);
    chk("go_hold_p1", p1_score, 5);
    chk("go_hold_armed", armed, 0);
    start = 1'b1;
    step(3);
    start = 1'b0;
    chk("clr_p1", p1_score, 0);
    chk("clr_p2", p2_score, 0);
    chk("clr_winner", winner, 0);
    chk("clr_react", reaction_ms, 0);
    go_armed(n);
    do_flip(1, 0, 20);
    chk("post_p1", p1_score, 1);
    chk("post_react", reaction_ms, 20);
    sw_p1 = 1'b0;
    step(6);
    tick = 1'b1;
    step(50);
    chk("mid_cd_armed", armed, 0);
    reset = 1'b0;
    #1;
    chk("arst_p1", p1_score, 0);
    chk("arst_react", reaction_ms, 0);
    chk("arst_armed", armed, 0);
    chk("arst_winner", winner, 0);
    chk("arst_pulse", round_pulse, 0);
    tick = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/reaction_referee.md
# reaction_referee

Game controller for the two-player reaction game. It sequences a pseudo-random countdown, arms the players' switches, and arbitrates which switch flipped first. It awards points, deducts points for early flips, and declares a winner at `WIN_SCORE`. It sits between the 1 ms clock-divider strobe, the start button and player switches, and the seven-segment score display.

## Interface
- `WIN_SCORE`, 5: points needed to win; 1..7.
- `MIN_DELAY_MS`, 1000: fixed part of the countdown, in ms.
- `RAND_BITS`, 10: width of the random countdown addend, giving 0..1023 ms extra.
- `TIMEOUT_MS`, 3000: armed window length before the round is voided.
- `LFSR_SEED`, 16'hACE1: reset value of the LFSR; must be nonzero.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low; all state cleared while low.
- `tick` in 1: 1 ms strobe, one `clk` cycle wide.
- `start` in 1: start button, active-high after board inversion; asynchronous.
- `sw_p1`, `sw_p2` in 1: player switches; asynchronous.
- `armed` out 1: high only in ARMED (the "go" LED).
- `p1_score`, `p2_score` out 3: current scores.
- `winner` out 2: 00 none, 01 P1, 10 P2.
- `round_pulse` out 1: one-cycle pulse when a round resolves.
- `reaction_ms` out 16: ARMED-to-flip time of the last point awarded.

## Operation
- `start`, `sw_p1` and `sw_p2` each pass through a 2-flop synchronizer.
- A rising-edge detector follows each synchronizer. "Edge" below means a synchronized rising edge.
- A 16-bit Fibonacci LFSR (taps 16,14,13,11) free-runs every `clk`.
- States and transitions:
  - IDLE: a `start` edge moves to WAIT_REL.
  - WAIT_REL: once both synced switches are low, load `cnt = MIN_DELAY_MS + lfsr[RAND_BITS-1:0]` and move to COUNTDOWN. Switch edges here are ignored.
  - COUNTDOWN: `cnt` decrements on each `tick`. When `cnt`==0, move to ARMED and clear `rt` (reaction timer).
    - An edge on a switch means that player is punished: score-1, saturating at 0.
    - Both edges in the same cycle punish both players.
    - Any punishment pulses `round_pulse` and returns to WAIT_REL.
  - ARMED: `rt` increments on `tick`, saturating at 16'hFFFF.
    - A single edge scores +1 for that player, latches `reaction_ms = rt`, pulses `round_pulse`, and moves to CHECK.
    - Edges from both players in the same cycle are a tie: no point, `reaction_ms` unchanged, pulse, then WAIT_REL.
    - `rt == TIMEOUT_MS` voids the round: no point, pulse, then WAIT_REL.
  - CHECK: if a score equals `WIN_SCORE`, set `winner` and move to GAMEOVER; otherwise move to WAIT_REL.
  - GAMEOVER: outputs hold. A `start` edge clears scores, `winner` and `reaction_ms`, then moves to WAIT_REL.
- Scores never exceed `WIN_SCORE`. A `start` edge outside IDLE and GAMEOVER is ignored.

## Timing
- Reset values: state IDLE, `armed` 0, scores 0, `winner` 00, `round_pulse` 0, `reaction_ms` 0, LFSR `LFSR_SEED`, `cnt` and `rt` 0.
- All outputs are registered.
- Input latency: a pin change shows as an edge 2 cycles later (synchronizer). The state and score update on the following `clk` edge, 3 cycles from the pin.
- `armed` rises on the first `clk` after `cnt` reaches 0, and falls on the same edge that the score updates.
- `winner` is valid 1 cycle after the final score update (the CHECK state).
- `round_pulse` is exactly 1 cycle wide, coincident with the score update.
- `tick` coinciding with an edge: the edge takes priority; the decrement is discarded.
- Reset asserted mid-operation returns to the reset values within the same cycle (asynchronous).

## Test plan
- Reset, then a `start` edge with switches low → WAIT_REL then COUNTDOWN. `armed` rises after 1000..2023 ticks.
- In ARMED, `sw_p1` rises 37 ticks after `armed` → `p1_score`=1, `reaction_ms`=37, one `round_pulse`, next state WAIT_REL.
- In COUNTDOWN with `p2_score`=2, `sw_p2` rises → `p2_score`=1 and the countdown restarts. A second early flip at 0 leaves the score at 0.
- Both switches rise in the same cycle while ARMED → scores unchanged, one `round_pulse`, `reaction_ms` unchanged.
- No flip for 3000 ticks in ARMED → `armed` falls, no score change, one `round_pulse`.
- P1 reaches 5 → `winner`=01, GAMEOVER holds; a `start` edge clears scores and `winner` to 0. Assert `reset` low mid-countdown → all outputs return to reset values immediately.
